// File: rtl/timebase_pkg.sv
// Shared definitions for the timebase: prescaler derivation, programmable-tick
// state encoding and timestamp width.
package timebase_pkg;

  localparam int unsigned TS_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } prog_state_t;

  // Clock cycles per microsecond; the clock must be an integer multiple of 1 MHz.
  function automatic int unsigned div_us(input int unsigned clk_freq_hz);
    return clk_freq_hz / 32'd1_000_000;
  endfunction

endpackage

// File: rtl/timebase_mod_cnt.sv
// Modulo-MOD event counter. Advances on inc while en is high, holds while en
// is low, clears synchronously. wrap is the combinational terminal event used
// to cascade the next stage; pulse is the same event registered as a strobe.
module timebase_mod_cnt
  import timebase_pkg::*;
#(
  parameter int unsigned MOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic inc,
  input  logic clr,
  output logic wrap,
  output logic pulse
);

  localparam int unsigned W = (MOD > 1) ? $clog2(MOD) : 1;
  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_d, cnt_q;
  logic         pulse_d, pulse_q;
  logic         last;

  // Next count and wrap detection; clear wins over any increment.
  always_comb begin
    last    = (cnt_q == LAST);
    wrap    = en & inc & ~clr & last;
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && inc) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
    pulse_d = wrap;
  end

  // Count and strobe registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/timebase_tick_gen.sv
// System timebase: 1 us / 1 ms / 1 s strobes, a programmable-period strobe
// with a shadow-register handshake, and a free-running microsecond timestamp.
module timebase_tick_gen
  import timebase_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 250_000_000,
  parameter int unsigned US_PER_MS   = 1000,
  parameter int unsigned MS_PER_S    = 1000,
  parameter int unsigned PROG_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              prog_valid,
  input  logic [PROG_W-1:0] prog_period,
  output logic              prog_ready,
  output logic              tick_us,
  output logic              tick_ms,
  output logic              tick_s,
  output logic              tick_prog,
  output logic [TS_W-1:0]   ts_us
);

  localparam int unsigned DIV_US = div_us(CLK_FREQ_HZ);

  logic us_wrap;
  logic ms_wrap;
  // The seconds stage ends the cascade, so its carry has no consumer.
  logic unused_s_wrap;

  timebase_mod_cnt #(.MOD(DIV_US)) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .inc   (1'b1),
    .clr   (clr),
    .wrap  (us_wrap),
    .pulse (tick_us)
  );

  timebase_mod_cnt #(.MOD(US_PER_MS)) u_ms (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .inc   (us_wrap),
    .clr   (clr),
    .wrap  (ms_wrap),
    .pulse (tick_ms)
  );

  timebase_mod_cnt #(.MOD(MS_PER_S)) u_s (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .inc   (ms_wrap),
    .clr   (clr),
    .wrap  (unused_s_wrap),
    .pulse (tick_s)
  );

  logic [TS_W-1:0] ts_d, ts_q;

  // Timestamp advances on the same edge that raises tick_us.
  always_comb begin
    ts_d = ts_q;
    if (clr) begin
      ts_d = '0;
    end else if (us_wrap) begin
      ts_d = ts_q + 1'b1;
    end
  end

  // Timestamp register.
  always_ff @(posedge clk) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_d;
  end

  assign ts_us = ts_q;

  // Programmable strobe: active period, shadow and counter.
  prog_state_t       state_d, state_q;
  logic [PROG_W-1:0] period_d, period_q;
  logic [PROG_W-1:0] shadow_d, shadow_q;
  logic [PROG_W-1:0] prog_cnt_d, prog_cnt_q;
  logic              ready_d, ready_q;
  logic              tick_prog_d, tick_prog_q;
  logic              accept;
  logic              prog_last;

  assign accept    = prog_valid & ready_q;
  assign prog_last = (prog_cnt_q == period_q - 1'b1);

  // In IDLE the shadow is full exactly when ready is low, so no extra state is
  // needed for the one-cycle apply after an accept.
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    shadow_d    = shadow_q;
    ready_d     = ready_q;
    prog_cnt_d  = prog_cnt_q;
    tick_prog_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ready_q) begin
          period_d   = shadow_q;
          prog_cnt_d = '0;
          ready_d    = 1'b1;
          state_d    = (shadow_q == '0) ? IDLE : RUN;
        end
      end
      RUN, PEND: begin
        if (us_wrap) begin
          if (prog_last) begin
            tick_prog_d = 1'b1;
            prog_cnt_d  = '0;
            if (state_q == PEND) begin
              period_d = shadow_q;
              ready_d  = 1'b1;
              state_d  = (shadow_q == '0) ? IDLE : RUN;
            end
          end else begin
            prog_cnt_d = prog_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      shadow_d = prog_period;
      ready_d  = 1'b0;
      if (state_q == RUN) state_d = PEND;
    end
    if (clr) begin
      prog_cnt_d  = '0;
      tick_prog_d = 1'b0;
    end
  end

  // Programmable-path state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      period_q    <= '0;
      shadow_q    <= '0;
      prog_cnt_q  <= '0;
      ready_q     <= 1'b1;
      tick_prog_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      shadow_q    <= shadow_d;
      prog_cnt_q  <= prog_cnt_d;
      ready_q     <= ready_d;
      tick_prog_q <= tick_prog_d;
    end
  end

  assign prog_ready = ready_q;
  assign tick_prog  = tick_prog_q;

endmodule
